// File: rtl/activation_stream_stage.sv
// Two-stage valid/ready wrapper around the activation LUT: S0 feeds LUT_INPUT, S1 registers
// the (exception-overridden) LUT result and tags layer ends. Optional perf counters: ACT_STAGE_PERF_EN.
module activation_stream_stage #(
  parameter int BIT_WIDTH    = 32,
  parameter int EXTRA_BITS   = 2,
  parameter int NEURON_COUNT = 16,
  parameter logic [BIT_WIDTH+EXTRA_BITS-1:0] SAT_POS = 34'h1_3F80_0000,
  parameter logic [BIT_WIDTH+EXTRA_BITS-1:0] SAT_NEG = 34'h1_0000_0000,
  parameter logic [BIT_WIDTH+EXTRA_BITS-1:0] NAN_VAL = 34'h3_0000_0000
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] IN_DATA,
  input  logic                            IN_LAST,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] LUT_INPUT,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] LUT_OUT,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] OUT_DATA,
  output logic                            OUT_LAST,
  input  logic                            CLR_ERR,
  output logic                            LEN_ERR
`ifdef ACT_STAGE_PERF_EN
  ,
  output logic [31:0]                     PERF_STALL,
  output logic [15:0]                     PERF_SPECIAL
`endif
);
  localparam int W  = BIT_WIDTH + EXTRA_BITS;
  localparam int IW = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(NEURON_COUNT - 1);

  logic          s0_valid_q, s0_valid_d;
  logic [W-1:0]  s0_data_q, s0_data_d;
  logic [IW-1:0] s0_idx_q, s0_idx_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          len_err_q, len_err_d;
  logic          s1_adv, in_acc, s1_load;
  logic [W-1:0]  act;

  assign s1_adv   = !out_valid_q || OUT_READY;
  assign IN_READY = !s0_valid_q || s1_adv;
  assign in_acc   = IN_VALID && IN_READY;
  assign s1_load  = s0_valid_q && s1_adv;

  assign LUT_INPUT = s0_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_LAST  = out_last_q;
  assign LEN_ERR   = len_err_q;

  // Exception field 10 is +/-inf, 11 is NaN; the LUT result is only trusted for 00/01.
  always_comb begin
    unique case (s0_data_q[W-1 -: 2])
      2'b10:   act = s0_data_q[BIT_WIDTH-1] ? SAT_NEG : SAT_POS;
      2'b11:   act = NAN_VAL;
      default: act = LUT_OUT;
    endcase
  end

  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_data_d   = s0_data_q;
    s0_idx_d    = s0_idx_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    len_err_d   = len_err_q;
    if (in_acc) begin
      s0_valid_d = 1'b1;
      s0_data_d  = IN_DATA;
      s0_idx_d   = idx_q;
      idx_d      = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else if (s1_adv) begin
      s0_valid_d = 1'b0;
    end
    if (s1_load) begin
      out_valid_d = 1'b1;
      out_data_d  = act;
      out_last_d  = (s0_idx_q == IDX_MAX);
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
    // A mismatch in the same cycle as CLR_ERR keeps the flag set.
    if (in_acc && (IN_LAST != (idx_q == IDX_MAX))) len_err_d = 1'b1;
    else if (CLR_ERR)                               len_err_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s0_valid_q  <= 1'b0;
      s0_data_q   <= '0;
      s0_idx_q    <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_data_q   <= s0_data_d;
      s0_idx_q    <= s0_idx_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      len_err_q   <= len_err_d;
    end
  end

`ifdef ACT_STAGE_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] spec_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
      spec_q  <= '0;
    end else if (CLR_ERR) begin
      stall_q <= '0;
      spec_q  <= '0;
    end else begin
      if (out_valid_q && !OUT_READY && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (s1_load && s0_data_q[W-1] && !(&spec_q))  spec_q  <= spec_q + 1'b1;
    end
  end

  assign PERF_STALL   = stall_q;
  assign PERF_SPECIAL = spec_q;
`else
  // Perf counters are compiled out in this build.
`endif
endmodule
